// File: rtl/mc_controller_v2_if.sv
// Purpose : control-unit <-> datapath bundle for the multicycle MIPS controller.
// Latency : none; wires only.
// Backpressure: memready_i stretches memory states when the controller is built to wait.
// Ports   : master = controller (drives datapath controls), slave = datapath/IR side.
interface mc_controller_v2_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op_i;
  logic               zero_i;
  logic               memready_i;
  logic               memread_o;
  logic               memwrite_o;
  logic               iord_o;
  logic               irwrite_o;
  logic               alusrca_o;
  logic               regwrite_o;
  logic               memsize_o;
  logic               pcen_o;
  logic [1:0]         regdst_o;
  logic [1:0]         memtoreg_o;
  logic [1:0]         pcsource_o;
  logic [2:0]         alusrcb_o;
  logic [2:0]         aluop_o;
  logic               exception_o;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op_i, zero_i, memready_i,
    output memread_o, memwrite_o, iord_o, irwrite_o, alusrca_o, regwrite_o,
           memsize_o, pcen_o, regdst_o, memtoreg_o, pcsource_o, alusrcb_o,
           aluop_o, exception_o, state_o
  );

  modport slave (
    output op_i, zero_i, memready_i,
    input  memread_o, memwrite_o, iord_o, irwrite_o, alusrca_o, regwrite_o,
           memsize_o, pcen_o, regdst_o, memtoreg_o, pcsource_o, alusrcb_o,
           aluop_o, exception_o, state_o
  );
endinterface

// File: rtl/mc_controller_v2.sv
// Purpose : multicycle MIPS FSM controller (R, J/JAL, BEQ/BNE, ADDI/ANDI/ORI, LB/LW, SB/SW, trap).
// Latency : outputs are combinational from the state register; 3-5 cycles per instruction.
// Backpressure: with WAIT_MEM=1, FETCH/MEMRD/MEMWR hold until memready_i; PC/IR writes held off.
// Ports   : clk, rst (sync, active-high); bus (master modport): op_i, zero_i, memready_i in,
//           datapath mux selects / enables, exception_o pulse and debug state_o out.
module mc_controller_v2 #(
  parameter int WAIT_MEM = 1,
  parameter int EXT_OPS  = 1,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  mc_controller_v2_if.master bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SW   = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = STATE_W'(0),
    S_DECODE = STATE_W'(1),
    S_MEMADR = STATE_W'(2),
    S_MEMRD  = STATE_W'(3),
    S_MEMWB  = STATE_W'(4),
    S_MEMWR  = STATE_W'(5),
    S_RTEX   = STATE_W'(6),
    S_RTWB   = STATE_W'(7),
    S_BREX   = STATE_W'(8),
    S_JEX    = STATE_W'(9),
    S_IEX    = STATE_W'(10),
    S_IWB    = STATE_W'(11),
    S_JALEX  = STATE_W'(12),
    S_TRAP   = STATE_W'(13)
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_ext;
  logic w_ready;
  logic w_op_r, w_op_j, w_op_jal, w_op_beq, w_op_bne, w_op_addi, w_op_andi, w_op_ori;
  logic w_op_lb, w_op_lw, w_op_sb, w_op_sw;
  logic w_load, w_store, w_branch, w_imm;
  logic w_bne;
  logic w_pcwrite, w_pcwritecond;

  assign w_ext   = (EXT_OPS != 0);
  assign w_ready = (WAIT_MEM != 0) ? bus.memready_i : 1'b1;

  // Extended opcodes are only recognised when EXT_OPS is set; otherwise they fall to TRAP.
  assign w_op_r    = (bus.op_i == OP_R);
  assign w_op_j    = (bus.op_i == OP_J);
  assign w_op_beq  = (bus.op_i == OP_BEQ);
  assign w_op_addi = (bus.op_i == OP_ADDI);
  assign w_op_lb   = (bus.op_i == OP_LB);
  assign w_op_sb   = (bus.op_i == OP_SB);
  assign w_op_jal  = w_ext & (bus.op_i == OP_JAL);
  assign w_op_bne  = w_ext & (bus.op_i == OP_BNE);
  assign w_op_andi = w_ext & (bus.op_i == OP_ANDI);
  assign w_op_ori  = w_ext & (bus.op_i == OP_ORI);
  assign w_op_lw   = w_ext & (bus.op_i == OP_LW);
  assign w_op_sw   = w_ext & (bus.op_i == OP_SW);

  assign w_load   = w_op_lb | w_op_lw;
  assign w_store  = w_op_sb | w_op_sw;
  assign w_branch = w_op_beq | w_op_bne;
  assign w_imm    = w_op_addi | w_op_andi | w_op_ori;

  // Raw compare: BREX is only reachable for BEQ/BNE, so no EXT gating is needed here.
  assign w_bne = (bus.op_i == OP_BNE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_load | w_store) w_next = S_MEMADR;
        else if (w_op_r)      w_next = S_RTEX;
        else if (w_branch)    w_next = S_BREX;
        else if (w_op_j)      w_next = S_JEX;
        else if (w_op_jal)    w_next = S_JALEX;
        else if (w_imm)       w_next = S_IEX;
        else                  w_next = S_TRAP;
      end
      S_MEMADR: w_next = w_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = w_ready ? S_FETCH : S_MEMWR;
      S_RTEX:   w_next = S_RTWB;
      S_IEX:    w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.memread_o   = 1'b0;
    bus.memwrite_o  = 1'b0;
    bus.iord_o      = 1'b0;
    bus.irwrite_o   = 1'b0;
    bus.alusrca_o   = 1'b0;
    bus.regwrite_o  = 1'b0;
    bus.memsize_o   = 1'b0;
    bus.regdst_o    = 2'b00;
    bus.memtoreg_o  = 2'b00;
    bus.pcsource_o  = 2'b00;
    bus.alusrcb_o   = 3'b000;
    bus.aluop_o     = 3'b000;
    bus.exception_o = 1'b0;
    w_pcwrite       = 1'b0;
    w_pcwritecond   = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC and IR only update on the cycle memory actually delivers.
        bus.memread_o = 1'b1;
        bus.alusrcb_o = 3'b001;
        bus.irwrite_o = w_ready;
        w_pcwrite     = w_ready;
      end
      S_DECODE: bus.alusrcb_o = 3'b011;
      S_MEMADR: begin
        bus.alusrca_o = 1'b1;
        bus.alusrcb_o = 3'b010;
      end
      S_MEMRD: begin
        bus.memread_o = 1'b1;
        bus.iord_o    = 1'b1;
        bus.memsize_o = w_op_lw;
      end
      S_MEMWB: begin
        bus.regwrite_o = 1'b1;
        bus.memtoreg_o = 2'b01;
      end
      S_MEMWR: begin
        bus.memwrite_o = 1'b1;
        bus.iord_o     = 1'b1;
        bus.memsize_o  = w_op_sw;
      end
      S_RTEX: begin
        bus.alusrca_o = 1'b1;
        bus.aluop_o   = 3'b010;
      end
      S_RTWB: begin
        bus.regwrite_o = 1'b1;
        bus.regdst_o   = 2'b01;
      end
      S_BREX: begin
        bus.alusrca_o  = 1'b1;
        bus.aluop_o    = 3'b001;
        bus.pcsource_o = 2'b01;
        w_pcwritecond  = 1'b1;
      end
      S_JEX: begin
        bus.pcsource_o = 2'b10;
        w_pcwrite      = 1'b1;
      end
      S_IEX: begin
        bus.alusrca_o = 1'b1;
        if (w_op_andi) begin
          bus.alusrcb_o = 3'b100;
          bus.aluop_o   = 3'b011;
        end else if (w_op_ori) begin
          bus.alusrcb_o = 3'b100;
          bus.aluop_o   = 3'b100;
        end else begin
          bus.alusrcb_o = 3'b010;
          bus.aluop_o   = 3'b000;
        end
      end
      S_IWB: begin
        bus.regwrite_o = 1'b1;
        bus.regdst_o   = 2'b00;
      end
      S_JALEX: begin
        // PC already holds PC+4 from FETCH; it goes to $31 while the jump target loads.
        bus.regwrite_o = 1'b1;
        bus.regdst_o   = 2'b10;
        bus.memtoreg_o = 2'b10;
        bus.pcsource_o = 2'b10;
        w_pcwrite      = 1'b1;
      end
      S_TRAP: bus.exception_o = 1'b1;
      default: ;
    endcase
  end

  // BNE inverts the sense of the zero flag for the conditional PC write.
  assign bus.pcen_o  = w_pcwrite | (w_pcwritecond & (bus.zero_i ^ w_bne));
  assign bus.state_o = r_state;

endmodule

// File: tb/tb_mc_controller_v2.sv
module tb_mc_controller_v2;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // A: waits on memory, full opcode set.  B: single-cycle memory, base opcodes only.
  mc_controller_v2_if #(.STATE_W(4)) bus_a ();
  mc_controller_v2_if #(.STATE_W(4)) bus_b ();

  mc_controller_v2 #(.WAIT_MEM(1), .EXT_OPS(1), .STATE_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mc_controller_v2 #(.WAIT_MEM(0), .EXT_OPS(0), .STATE_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // ---------------- reference model ----------------
  // Each instruction is a fixed walk through states; memory states repeat while not ready.
  function automatic int path_state(input logic [5:0] op, input bit ext, input int idx);
    int tail[3];
    int n;
    tail = '{13, 0, 0};
    n    = 1;
    if (idx == 0) return 0;
    if (idx == 1) return 1;
    if (op == OP_R)                                   begin tail = '{6, 7, 0};  n = 2; end
    else if (op == OP_LB || (ext && op == OP_LW))     begin tail = '{2, 3, 4};  n = 3; end
    else if (op == OP_SB || (ext && op == OP_SW))     begin tail = '{2, 5, 0};  n = 2; end
    else if (op == OP_BEQ || (ext && op == OP_BNE))   begin tail = '{8, 0, 0};  n = 1; end
    else if (op == OP_J)                              begin tail = '{9, 0, 0};  n = 1; end
    else if (ext && op == OP_JAL)                     begin tail = '{12, 0, 0}; n = 1; end
    else if (op == OP_ADDI || (ext && (op == OP_ANDI || op == OP_ORI)))
                                                      begin tail = '{10, 11, 0}; n = 2; end
    if (idx - 2 < n) return tail[idx-2];
    return -1;
  endfunction

  function automatic int advance(input int idx, input logic [5:0] op, input bit wm,
                                 input bit ext, input logic ready);
    int s;
    s = path_state(op, ext, idx);
    if (wm && !ready && (s == 0 || s == 3 || s == 5)) return idx;
    if (path_state(op, ext, idx + 1) < 0) return 0;
    return idx + 1;
  endfunction

  // Packed as {memread, memwrite, iord, irwrite, alusrca, regwrite, memsize, pcen,
  //            regdst[2], memtoreg[2], pcsource[2], alusrcb[3], aluop[3], exception}
  function automatic logic [20:0] exp_out(input int s, input logic [5:0] op, input logic zero,
                                          input logic ready, input bit wm);
    logic rdy, mr, mw, io, ir, sa, rw, ms, pc, ex, word, taken;
    logic [1:0] rd, mt, ps;
    logic [2:0] sb, ao;
    rdy = wm ? ready : 1'b1;
    {mr, mw, io, ir, sa, rw, ms, pc, ex} = '0;
    rd = 0; mt = 0; ps = 0; sb = 0; ao = 0;
    word  = (op == OP_LW) || (op == OP_SW);
    taken = (op == OP_BNE) ? !zero : zero;
    case (s)
      0:  begin mr = 1; sb = 3'd1; ir = rdy; pc = rdy; end
      1:  sb = 3'd3;
      2:  begin sa = 1; sb = 3'd2; end
      3:  begin mr = 1; io = 1; ms = word; end
      4:  begin rw = 1; mt = 2'd1; end
      5:  begin mw = 1; io = 1; ms = word; end
      6:  begin sa = 1; ao = 3'd2; end
      7:  begin rw = 1; rd = 2'd1; end
      8:  begin sa = 1; ao = 3'd1; ps = 2'd1; pc = taken; end
      9:  begin ps = 2'd2; pc = 1; end
      10: begin
        sa = 1;
        if (op == OP_ANDI)     begin sb = 3'd4; ao = 3'd3; end
        else if (op == OP_ORI) begin sb = 3'd4; ao = 3'd4; end
        else                   begin sb = 3'd2; ao = 3'd0; end
      end
      11: rw = 1;
      12: begin rw = 1; rd = 2'd2; mt = 2'd2; ps = 2'd2; pc = 1; end
      13: ex = 1;
      default: ;
    endcase
    return {mr, mw, io, ir, sa, rw, ms, pc, rd, mt, ps, sb, ao, ex};
  endfunction

  int idx_a = 0;
  int idx_b = 0;
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      idx_a  <= 0;
      idx_b  <= 0;
      mvalid <= 1'b1;
    end else begin
      idx_a <= advance(idx_a, bus_a.op_i, 1'b1, 1'b1, bus_a.memready_i);
      idx_b <= advance(idx_b, bus_b.op_i, 1'b0, 1'b0, bus_b.memready_i);
    end
  end

  logic [20:0] act_a, act_b;
  assign act_a = {bus_a.memread_o, bus_a.memwrite_o, bus_a.iord_o, bus_a.irwrite_o,
                  bus_a.alusrca_o, bus_a.regwrite_o, bus_a.memsize_o, bus_a.pcen_o,
                  bus_a.regdst_o, bus_a.memtoreg_o, bus_a.pcsource_o, bus_a.alusrcb_o,
                  bus_a.aluop_o, bus_a.exception_o};
  assign act_b = {bus_b.memread_o, bus_b.memwrite_o, bus_b.iord_o, bus_b.irwrite_o,
                  bus_b.alusrca_o, bus_b.regwrite_o, bus_b.memsize_o, bus_b.pcen_o,
                  bus_b.regdst_o, bus_b.memtoreg_o, bus_b.pcsource_o, bus_b.alusrcb_o,
                  bus_b.aluop_o, bus_b.exception_o};

  always @(negedge clk) begin
    if (mvalid) begin
      int es_a, es_b;
      logic [20:0] ev_a, ev_b;
      es_a = path_state(bus_a.op_i, 1'b1, idx_a);
      es_b = path_state(bus_b.op_i, 1'b0, idx_b);
      ev_a = exp_out(es_a, bus_a.op_i, bus_a.zero_i, bus_a.memready_i, 1'b1);
      ev_b = exp_out(es_b, bus_b.op_i, bus_b.zero_i, bus_b.memready_i, 1'b0);
      checks += 4;
      if (int'(bus_a.state_o) != es_a) begin
        errors++;
        $display("FAIL model_state_a t=%0t: got %0d expected %0d", $time, bus_a.state_o, es_a);
      end
      if (act_a !== ev_a) begin
        errors++;
        $display("FAIL model_outs_a t=%0t: got %h expected %h", $time, act_a, ev_a);
      end
      if (int'(bus_b.state_o) != es_b) begin
        errors++;
        $display("FAIL model_state_b t=%0t: got %0d expected %0d", $time, bus_b.state_o, es_b);
      end
      if (act_b !== ev_b) begin
        errors++;
        $display("FAIL model_outs_b t=%0t: got %h expected %h", $time, act_b, ev_b);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_branch(input logic [5:0] op, input logic z, input logic exp_pcen);
    next_cycle(); bus_a.op_i = op; bus_a.zero_i = z; bus_a.memready_i = 1'b1;
    @(negedge clk); chk("br_fetch_state", 32'(bus_a.state_o), 0);
    next_cycle(); @(negedge clk); chk("br_decode_state", 32'(bus_a.state_o), 1);
    next_cycle(); @(negedge clk); chk("br_brex_state", 32'(bus_a.state_o), 8);
    chk("br_pcen", 32'(bus_a.pcen_o), 32'(exp_pcen));
  endtask

  int rseq[3]   = '{1, 6, 7};
  int lw_st[9]  = '{0, 0, 0, 1, 2, 3, 3, 3, 4};
  int lw_rdy[9] = '{0, 0, 1, 1, 1, 0, 0, 1, 1};
  int sw_st[5]  = '{0, 1, 2, 5, 5};
  int sw_rdy[5] = '{1, 1, 1, 0, 0};
  int bseq[4]   = '{0, 1, 13, 0};

  initial begin
    int pulses;
    rst = 1'b1;
    bus_a.op_i = OP_R; bus_a.zero_i = 1'b0; bus_a.memready_i = 1'b1;
    bus_b.op_i = OP_R; bus_b.zero_i = 1'b0; bus_b.memready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_state", 32'(bus_a.state_o), 0);
    chk("reset_memread", 32'(bus_a.memread_o), 1);
    chk("reset_alusrcb", 32'(bus_a.alusrcb_o), 1);
    chk("reset_pcen", 32'(bus_a.pcen_o), 1);
    chk("reset_irwrite", 32'(bus_a.irwrite_o), 1);
    chk("reset_memwrite", 32'(bus_a.memwrite_o), 0);
    chk("reset_regwrite", 32'(bus_a.regwrite_o), 0);

    // R-type: 0 -> 1 -> 6 -> 7 -> 0 on both controllers.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      chk("r_state_a", 32'(bus_a.state_o), 32'(rseq[i]));
      chk("r_state_b", 32'(bus_b.state_o), 32'(rseq[i]));
      chk("r_regwrite", 32'(bus_a.regwrite_o), (rseq[i] == 7) ? 1 : 0);
      chk("r_regdst", 32'(bus_a.regdst_o), (rseq[i] == 7) ? 1 : 0);
    end

    // LW with two wait cycles in FETCH and two in MEMRD: 9 cycles, one pcen pulse.
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      bus_a.op_i = OP_LW;
      bus_a.memready_i = lw_rdy[c][0];
      @(negedge clk);
      chk("lw_state", 32'(bus_a.state_o), 32'(lw_st[c]));
      pulses += int'(bus_a.pcen_o);
      if (lw_st[c] == 0) chk("lw_fetch_memread", 32'(bus_a.memread_o), 1);
      if (lw_st[c] == 3) chk("lw_memsize", 32'(bus_a.memsize_o), 1);
    end
    chk("lw_pcen_pulses", 32'(pulses), 1);

    run_branch(OP_BNE, 1'b0, 1'b1);
    run_branch(OP_BNE, 1'b1, 1'b0);
    run_branch(OP_BEQ, 1'b0, 1'b0);
    run_branch(OP_BEQ, 1'b1, 1'b1);

    // JAL: 0, 1, 12.
    next_cycle(); bus_a.op_i = OP_JAL; bus_a.zero_i = 1'b0;
    @(negedge clk); chk("jal_fetch", 32'(bus_a.state_o), 0);
    next_cycle(); @(negedge clk); chk("jal_decode", 32'(bus_a.state_o), 1);
    next_cycle(); @(negedge clk);
    chk("jal_state", 32'(bus_a.state_o), 12);
    chk("jal_regdst", 32'(bus_a.regdst_o), 2);
    chk("jal_memtoreg", 32'(bus_a.memtoreg_o), 2);
    chk("jal_pcsource", 32'(bus_a.pcsource_o), 2);
    chk("jal_pcen", 32'(bus_a.pcen_o), 1);
    chk("jal_regwrite", 32'(bus_a.regwrite_o), 1);

    // Illegal opcode: 0, 1, 13 with a single exception pulse.
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      bus_a.op_i = OP_BAD;
      @(negedge clk);
      pulses += int'(bus_a.exception_o);
      if (c == 2) chk("trap_state", 32'(bus_a.state_o), 13);
    end
    chk("trap_pulses", 32'(pulses), 1);

    // SW stalled in MEMWR, then reset while waiting.
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      bus_a.op_i = OP_SW;
      bus_a.memready_i = sw_rdy[c][0];
      @(negedge clk);
      chk("sw_state", 32'(bus_a.state_o), 32'(sw_st[c]));
      if (sw_st[c] == 5) chk("sw_memwrite", 32'(bus_a.memwrite_o), 1);
    end
    next_cycle(); rst = 1'b1;
    @(negedge clk);
    chk("sw_wait_before_rst", 32'(bus_a.state_o), 5);

    // After the reset edge: A idles in FETCH (memory not ready); B runs ORI, which traps.
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      if (c == 0) begin
        rst = 1'b0;
        bus_b.op_i = OP_ORI;
      end
      @(negedge clk);
      chk("rst_state_a", 32'(bus_a.state_o), 0);
      chk("rst_memwrite_a", 32'(bus_a.memwrite_o), 0);
      chk("ori_state_b", 32'(bus_b.state_o), 32'(bseq[c]));
      pulses += int'(bus_b.exception_o);
    end
    chk("ori_trap_pulses_b", 32'(pulses), 1);

    // Let A finish its SW and run one ADDI under the model.
    bus_a.memready_i = 1'b1;
    repeat (4) next_cycle();
    bus_a.op_i = OP_ADDI;
    repeat (6) next_cycle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mc_controller_v2.md
# mc_controller_v2

Parametrised multicycle MIPS control unit, the next generation of the core's FSM controller. It adds byte/word memory access, BNE, JAL, ANDI/ORI and an illegal-opcode trap, plus an optional memory-ready handshake that stretches memory states. It sits between the instruction register (op_i), the ALU zero flag and the datapath muxes/enables.

## Interface
- WAIT_MEM, 1: 1 = memory states hold until memready_i; 0 = memready_i ignored, memory is single-cycle.
- EXT_OPS, 1: 1 = LW/SW/BNE/JAL/ANDI/ORI decoded; 0 = those opcodes trap as illegal.
- STATE_W, 4: width of state register and state_o.

- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- op_i  in  6  IR[31:26]; stable from DECODE to end of instruction.
- zero_i  in  1  ALU zero flag.
- memready_i  in  1  memory access completes this cycle.
- memread_o, memwrite_o, iord_o, irwrite_o, alusrca_o, regwrite_o  out  1  datapath controls.
- memsize_o  out  1  0 = byte, 1 = word.
- pcen_o  out  1  PC load enable.
- regdst_o  out  2  00 rt, 01 rd, 10 register 31.
- memtoreg_o  out  2  00 ALUOut, 01 MDR, 10 PC.
- pcsource_o  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- alusrcb_o  out  3  000 B, 001 const 4, 010 sign-ext imm, 011 sign-ext imm<<2, 100 zero-ext imm.
- aluop_o  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or.
- exception_o  out  1  one-cycle pulse on illegal opcode.
- state_o  out  STATE_W  current state, debug.

## Operation
- Opcodes: R 000000, J 000010, JAL 000011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, LB 100000, LW 100011, SB 101000, SW 101011.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BREX 8, JEX 9, IEX 10, IWB 11, JALEX 12, TRAP 13. Unused encodings -> FETCH.
- Transitions: FETCH -> DECODE (only when ready). DECODE -> MEMADR (LB/LW/SB/SW), RTEX, BREX (BEQ/BNE), JEX, JALEX, IEX (ADDI/ANDI/ORI), else TRAP. MEMADR -> MEMRD (loads) / MEMWR (stores). MEMRD -> MEMWB when ready. MEMWR -> FETCH when ready. RTEX -> RTWB; IEX -> IWB. MEMWB, RTWB, IWB, BREX, JEX, JALEX, TRAP -> FETCH.
- "ready" = memready_i when WAIT_MEM=1, else constant 1.
- All outputs default 0; per state, only listed signals asserted:
  - FETCH: memread=1, alusrcb=001; irwrite=pcwrite=ready.
  - DECODE: alusrcb=011.
  - MEMADR: alusrca=1, alusrcb=010.
  - MEMRD: memread=1, iord=1, memsize.
  - MEMWB: regwrite=1, memtoreg=01.
  - MEMWR: memwrite=1, iord=1, memsize.
  - RTEX: alusrca=1, aluop=010. RTWB: regwrite=1, regdst=01.
  - BREX: alusrca=1, aluop=001, pcsource=01, pcwritecond=1.
  - JEX: pcsource=10, pcwrite=1.
  - IEX: alusrca=1; ADDI alusrcb=010/aluop=000; ANDI 100/011; ORI 100/100.
  - IWB: regwrite=1, regdst=00.
  - JALEX: regwrite=1, regdst=10, memtoreg=10, pcsource=10, pcwrite=1.
  - TRAP: exception_o=1.
- memsize_o = 1 for LW/SW, 0 for LB/SB; 0 outside MEMRD/MEMWR.
- pcen_o = pcwrite | (pcwritecond & (zero_i ^ bne)), where bne = (op_i==BNE). Combinational.
- EXT_OPS=0: LW, SW, BNE, JAL, ANDI, ORI decode to TRAP.

## Timing
- Reset: state=FETCH on the next posedge with rst=1. Outputs after reset are the FETCH values: memread=1, alusrcb=001, irwrite=pcen=ready; all others 0.
- Reset has priority over any in-progress or waiting state. No write strobe is issued after the reset edge.
- Outputs are decoded combinationally from state, with op_i, zero_i and memready_i as qualifiers. No registered-output latency.
- Cycles per instruction with WAIT_MEM=0: R/ADDI/ANDI/ORI 4, LB/LW 5, SB/SW 4, BEQ/BNE/J/JAL 3, illegal 3.
- Each memory state (FETCH, MEMRD, MEMWR) adds one cycle per cycle memready_i is low. During a wait, memread/memwrite stay high and pcen/irwrite stay 0, so PC and IR do not change.
- JALEX writes the PC value already incremented in FETCH (PC+4) to register 31, in the same cycle the jump target is loaded into the PC.

## Test plan
- rst=1 for 2 cycles, then rst=0 with op_i=R -> state_o sequence 0,1,6,7,0; regdst=01 and regwrite=1 only in state 7.
- LW (100011), WAIT_MEM=1, memready_i low 2 cycles in FETCH and in MEMRD -> 9 cycles total; pcen pulses exactly once in FETCH; memsize=1 in MEMRD.
- BNE with zero_i=0 -> pcen=1 in BREX. BNE with zero_i=1 -> pcen=0. BEQ -> the inverse of both.
- JAL -> states 0,1,12; in state 12: regdst=10, memtoreg=10, pcsource=10, pcen=1, regwrite=1.
- op_i=111111 -> TRAP with a single exception_o pulse, then FETCH. With EXT_OPS=0, op_i=ORI also traps.
- rst asserted while in MEMWR waiting -> state_o=0 next cycle; memwrite_o=0 from then on.
